// File: rtl/ram_fsm_pkg.sv
// ----------------------------------------------------------------------------
// ram_fsm_pkg
// Types and constants used by the RAM fill/playback demo (ram_fsm_top).
//   state_e       - sequencer states: IDLE, FILL, PLAY, PAUSE
//   DEPTH_DEF     - default number of RAM words
//   DATA_W_DEF    - default RAM word width (equals the LED count)
//   PRESCALE_DEF  - default clocks per playback step
//   fill_pattern  - value written to each RAM word during FILL
// ----------------------------------------------------------------------------
package ram_fsm_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      PLAY  = 2'd2,
      PAUSE = 2'd3
   } state_e;

   localparam int DEPTH_DEF    = 16;
   localparam int DATA_W_DEF   = 4;
   localparam int PRESCALE_DEF = 8;

   // Bitwise NOT of the address; the caller truncates to its word width.
   function automatic logic [31:0] fill_pattern(input logic [31:0] addr);
      return ~addr;
   endfunction

endpackage : ram_fsm_pkg

// File: rtl/ram_sp.sv
// ----------------------------------------------------------------------------
// ram_sp
// Single-port synchronous RAM with a registered read port.
// A read that coincides with a write to the same word returns the old data.
// Ports:
//   clock    in   rising-edge clock
//   we_i     in   write enable
//   addr_i   in   ADDR_W-bit word address (shared by read and write)
//   wdata_i  in   DATA_W-bit write data
//   rdata_o  out  DATA_W-bit read data, one clock after the address
// ----------------------------------------------------------------------------
module ram_sp #(
   parameter int DEPTH  = 16,
   parameter int DATA_W = 4,
   parameter int ADDR_W = 4
) (
   input  logic              clock,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   // NOTE: the storage array has no reset so it maps onto block/distributed
   // RAM; only control registers elsewhere are reset.
   always_ff @(posedge clock) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
      rdata_q <= mem_q[addr_i];
   end

   assign rdata_o = rdata_q;

endmodule : ram_sp

// File: rtl/ram_fsm_top.sv
// ----------------------------------------------------------------------------
// ram_fsm_top
// Fills a small single-port RAM with the pattern ~addr, then plays it back on
// the LEDs, one word every PRESCALE clocks. i_enable starts the fill and
// run/pauses playback; o_led_r is lit while playback is stopped.
// Ports:
//   clock     in   board clock, rising edge
//   i_reset   in   synchronous reset, active low
//   i_enable  in   run/pause request, sampled every clock
//   o_leds    out  DATA_W-bit registered RAM word on the LEDs
//   o_led_r   out  registered status LED (1 in IDLE/PAUSE, 0 in FILL/PLAY)
// Build option:
//   PAUSE_BLINK_EN - when defined, o_led_r blinks every PRESCALE clocks in
//                    PAUSE and playback resumes with the prescaler cleared.
// ----------------------------------------------------------------------------
module ram_fsm_top
   import ram_fsm_pkg::*;
#(
   parameter int DEPTH    = DEPTH_DEF,
   parameter int DATA_W   = DATA_W_DEF,
   parameter int PRESCALE = PRESCALE_DEF
) (
   input  logic              clock,
   input  logic              i_reset,
   input  logic              i_enable,
   output logic [DATA_W-1:0] o_leds,
   output logic              o_led_r
);

   localparam int AW = (DEPTH    > 1) ? $clog2(DEPTH)    : 1;
   localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   localparam logic [AW-1:0] ADDR_ONE  = AW'(1);
   localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [CW-1:0] CNT_LAST  = CW'(PRESCALE - 1);

   state_e            state_q, state_d;
   logic [AW-1:0]     addr_q,  addr_d;
   logic [CW-1:0]     cnt_q,   cnt_d;
   logic [DATA_W-1:0] leds_q,  leds_d;
   logic              led_r_q, led_r_d;

   logic              ram_we;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;

   // The RAM reads addr_q every clock. addr_q is stable for a whole step, so
   // by the step edge ram_rdata already holds mem[addr_q]; this hides the
   // one-clock read latency (needs PRESCALE >= 2).
   ram_sp #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W),
      .ADDR_W (AW)
   ) u_ram (
      .clock   (clock),
      .we_i    (ram_we),
      .addr_i  (addr_q),
      .wdata_i (ram_wdata),
      .rdata_o (ram_rdata)
   );

   // NOTE: every signal driven here gets a default first, so no path through
   // the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      cnt_d     = cnt_q;
      leds_d    = leds_q;
      ram_we    = 1'b0;
      ram_wdata = DATA_W'(fill_pattern(32'(addr_q)));

      unique case (state_q)
         IDLE: begin
            if (i_enable) begin
               state_d = FILL;
               addr_d  = '0;
            end
         end

         // i_enable is deliberately ignored: a fill always runs to the end.
         FILL: begin
            ram_we = 1'b1;
            addr_d = addr_q + ADDR_ONE;
            if (addr_q == ADDR_LAST) begin
               state_d = PLAY;
               addr_d  = '0;
               cnt_d   = '0;
            end
         end

         PLAY: begin
            if (!i_enable) begin
               // Pausing edge: no count, no step.
               state_d = PAUSE;
`ifdef PAUSE_BLINK_EN
               cnt_d   = '0;
`endif
            end else if (cnt_q == CNT_LAST) begin
               leds_d = ram_rdata;
               addr_d = addr_q + ADDR_ONE;   // wraps since DEPTH is 2**AW
               cnt_d  = '0;
            end else begin
               cnt_d  = cnt_q + CNT_ONE;
            end
         end

         PAUSE: begin
            if (i_enable) begin
               state_d = PLAY;
`ifdef PAUSE_BLINK_EN
               cnt_d   = '0;
`endif
            end
`ifdef PAUSE_BLINK_EN
            else begin
               // Counter free-runs only to time the blink.
               cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_ONE;
            end
`endif
         end

         default: state_d = IDLE;
      endcase

      // Status LED follows the state being entered, so it changes on the
      // same edge as the transition.
      led_r_d = (state_d == IDLE) || (state_d == PAUSE);
`ifdef PAUSE_BLINK_EN
      if ((state_q == PAUSE) && (state_d == PAUSE)) begin
         led_r_d = (cnt_q == CNT_LAST) ? ~led_r_q : led_r_q;
      end
`endif
   end

   // NOTE: state registers use non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clock) begin
      if (!i_reset) begin
         state_q <= IDLE;
         addr_q  <= '0;
         cnt_q   <= '0;
         leds_q  <= '0;
         led_r_q <= 1'b1;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         leds_q  <= leds_d;
         led_r_q <= led_r_d;
      end
   end

   assign o_leds  = leds_q;
   assign o_led_r = led_r_q;

endmodule : ram_fsm_top

// File: tb/tb_ram_fsm_top.sv
// ----------------------------------------------------------------------------
// tb_ram_fsm_top
// Directed bench for ram_fsm_top at default parameters (DEPTH=16, DATA_W=4,
// PRESCALE=8). Inputs change 1 ns after a rising edge and outputs are sampled
// at the same point. Compiling with PAUSE_BLINK_EN switches the pause
// expectations to the blinking variant.
// ----------------------------------------------------------------------------
module tb_ram_fsm_top;

   localparam int DEPTH    = 16;
   localparam int DATA_W   = 4;
   localparam int PRESCALE = 8;

`ifdef PAUSE_BLINK_EN
   localparam int       RESUME_EDGES = PRESCALE;   // counter restarts at 0
   localparam bit       LED_R_MID    = 1'b0;       // first blink after 8 edges
`else
   localparam int       RESUME_EDGES = 5;          // 3 already counted, 3..7 then step
   localparam bit       LED_R_MID    = 1'b1;
`endif

   logic              clock;
   logic              i_reset;
   logic              i_enable;
   logic [DATA_W-1:0] o_leds;
   logic              o_led_r;

   int checks;
   int errors;

   ram_fsm_top #(
      .DEPTH    (DEPTH),
      .DATA_W   (DATA_W),
      .PRESCALE (PRESCALE)
   ) dut (
      .clock    (clock),
      .i_reset  (i_reset),
      .i_enable (i_enable),
      .o_leds   (o_leds),
      .o_led_r  (o_led_r)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #200_000;
      $display("FAIL watchdog: observed no finish, expected finish before 200 us");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reset edge, then release reset and run through FILL into PLAY up to the
   // first step. Enable is high throughout.
   task automatic refill_to_first_step(input string tag);
      i_reset = 1'b1;
      tick();                         // IDLE -> FILL
      check({tag, "_fill_led_r"}, 32'(o_led_r), 32'h0);
      ticks(DEPTH);                   // DEPTH fill edges, last one enters PLAY
      ticks(PRESCALE - 1);
      check({tag, "_pre_step"}, 32'(o_leds), 32'h0);
      tick();
      check({tag, "_first_step"}, 32'(o_leds), 32'hF);
   endtask

   initial begin
      logic [DATA_W-1:0] prev_v;
      logic [DATA_W-1:0] exp_v;

      checks   = 0;
      errors   = 0;
      i_reset  = 1'b0;
      i_enable = 1'b0;

      // Reset for 3 clocks, then idle with enable low.
      ticks(3);
      check("reset_leds",  32'(o_leds),  32'h0);
      check("reset_led_r", 32'(o_led_r), 32'h1);
      i_reset = 1'b1;
      ticks(3);
      check("idle_leds",  32'(o_leds),  32'h0);
      check("idle_led_r", 32'(o_led_r), 32'h1);

      // Fill: 16 clocks, status LED dark throughout.
      i_enable = 1'b1;
      tick();
      check("fill_entry_led_r", 32'(o_led_r), 32'h0);
      ticks(DEPTH - 1);
      check("fill_end_led_r", 32'(o_led_r), 32'h0);
      check("fill_end_leds",  32'(o_leds),  32'h0);
      tick();                          // last fill edge, enters PLAY
      ticks(PRESCALE - 1);
      check("first_step_early", 32'(o_leds), 32'h0);
      tick();
      check("first_step", 32'(o_leds), 32'hF);
      check("play_led_r", 32'(o_led_r), 32'h0);

      // Playback: E, D, ... 0, then wrap to F, one value every 8 clocks.
      prev_v = 4'hF;
      for (int k = 1; k <= DEPTH; k++) begin
         ticks(PRESCALE - 1);
         check($sformatf("play_hold_%0d", k), 32'(o_leds), 32'(prev_v));
         tick();
         exp_v = 4'(15 - (k % 16));
         check($sformatf("play_step_%0d", k), 32'(o_leds), 32'(exp_v));
         prev_v = exp_v;
      end

      // Pause mid-step (3 counts in), hold 20 clocks, resume.
      ticks(3);
      i_enable = 1'b0;
      tick();
      check("pause_led_r", 32'(o_led_r), 32'h1);
      ticks(8);
      check("pause_led_r_8",  32'(o_led_r), 32'(LED_R_MID));
      check("pause_leds_8",   32'(o_leds),  32'hF);
      ticks(8);
      check("pause_led_r_16", 32'(o_led_r), 32'h1);
      ticks(4);
      check("pause_leds_20",  32'(o_leds),  32'hF);
      i_enable = 1'b1;
      tick();
      check("resume_led_r", 32'(o_led_r), 32'h0);
      ticks(RESUME_EDGES - 1);
      check("resume_hold", 32'(o_leds), 32'hF);
      tick();
      check("resume_step", 32'(o_leds), 32'hE);

`ifndef PAUSE_BLINK_EN
      // Choppy enable: pause, resume, count. One count per three clocks, so
      // the step lands at the end of the 8th group - delayed, not skipped.
      for (int g = 1; g <= PRESCALE; g++) begin
         i_enable = 1'b0;
         tick();
         if (g == 1) check("choppy_pause_led_r", 32'(o_led_r), 32'h1);
         i_enable = 1'b1;
         ticks(2);
         if (g == PRESCALE - 1) check("choppy_hold", 32'(o_leds), 32'hE);
      end
      check("choppy_step", 32'(o_leds), 32'hD);
      check("choppy_led_r", 32'(o_led_r), 32'h0);
`endif

      // Reset mid-FILL, then refill from address 0.
      i_enable = 1'b1;
      i_reset  = 1'b0;
      tick();
      i_reset  = 1'b1;
      tick();                          // IDLE -> FILL
      ticks(5);
      check("midfill_led_r", 32'(o_led_r), 32'h0);
      i_reset = 1'b0;
      tick();
      check("midfill_reset_leds",  32'(o_leds),  32'h0);
      check("midfill_reset_led_r", 32'(o_led_r), 32'h1);
      refill_to_first_step("refill1");
      ticks(PRESCALE);
      check("refill1_second", 32'(o_leds), 32'hE);

      // Reset mid-PLAY, then refill and restart at F.
      ticks(3);
      i_reset = 1'b0;
      tick();
      check("midplay_reset_leds",  32'(o_leds),  32'h0);
      check("midplay_reset_led_r", 32'(o_led_r), 32'h1);
      refill_to_first_step("refill2");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_ram_fsm_top
